// File: rtl/wb_demux14_if.sv
// Write-back demux bus: one producer port plus four consumer channels.
interface wb_demux14_if #(parameter int unsigned WIDTH = 8);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       s;
   logic [WIDTH-1:0] d;
   logic             v0, v1, v2, v3;
   logic [WIDTH-1:0] y0, y1, y2, y3;
   logic             r0, r1, r2, r3;

   modport slave (
      input  in_valid, s, d, r0, r1, r2, r3,
      output in_ready, v0, v1, v2, v3, y0, y1, y2, y3
   );

   modport master (
      output in_valid, s, d, r0, r1, r2, r3,
      input  in_ready, v0, v1, v2, v3, y0, y1, y2, y3
   );
endinterface

// File: rtl/wb_demux14.sv
// 1-to-4 write-back demultiplexer with a single-entry valid/ready holding buffer.
// Optional per-channel delivery counters on port cnt when WB_DEMUX_CNT_EN is defined.
module wb_demux14 #(
   parameter int unsigned WIDTH = 8
) (
   input logic          clk,
   input logic          rst,
   wb_demux14_if.slave  bus
`ifdef WB_DEMUX_CNT_EN
   ,
   output logic [31:0]  cnt
`endif
);

   localparam int unsigned NCH = 4;

   typedef enum logic {EMPTY, FULL} state_t;

   state_t           state;
   logic [WIDTH-1:0] buf_d;
   logic [1:0]       buf_s;
   logic [NCH-1:0]   r;
   logic [NCH-1:0]   v;
   logic             drain;
   logic             accept;

   assign r = {bus.r3, bus.r2, bus.r1, bus.r0};

   // One-hot valid decode of the held word's destination
   always_comb begin
      v = '0;
      if (state == FULL) v[buf_s] = 1'b1;
   end

   // Only the selected consumer's ready can free the buffer
   assign drain        = |(v & r);
   assign bus.in_ready = (state == EMPTY) | drain;
   assign accept       = bus.in_valid & bus.in_ready;

   assign bus.v0 = v[0];
   assign bus.v1 = v[1];
   assign bus.v2 = v[2];
   assign bus.v3 = v[3];
   assign bus.y0 = v[0] ? buf_d : '0;
   assign bus.y1 = v[1] ? buf_d : '0;
   assign bus.y2 = v[2] ? buf_d : '0;
   assign bus.y3 = v[3] ? buf_d : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= EMPTY;
         buf_d <= '0;
         buf_s <= '0;
      end else if (accept) begin
         state <= FULL;
         buf_d <= bus.d;
         buf_s <= bus.s;
      end else if (drain) begin
         state <= EMPTY;
      end
   end

`ifdef WB_DEMUX_CNT_EN
   logic [7:0] cnt_q [NCH];

   // Free-running 8-bit delivery counters, wrapping silently
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) cnt_q[i] <= 8'd0;
      end else begin
         for (int i = 0; i < NCH; i++)
            if (v[i] & r[i]) cnt_q[i] <= cnt_q[i] + 8'd1;
      end
   end

   assign cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_wb_demux14.sv
// Self-checking bench for wb_demux14: directed scenarios plus randomized traffic vs a queue model.
module tb_wb_demux14;
   localparam int unsigned W  = 8;
   localparam int unsigned VW = 5 + 4 * W;

   typedef struct packed {
      logic [1:0]   s;
      logic [W-1:0] d;
   } item_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   item_t q[$];
   int   cnt_m[4];

   wb_demux14_if #(.WIDTH(W)) bus ();

`ifdef WB_DEMUX_CNT_EN
   logic [31:0] cnt;
   wb_demux14 #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus), .cnt(cnt));
`else
   wb_demux14 #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   always #5 clk = ~clk;

   function automatic logic [VW-1:0] obs_vec();
      return {bus.in_ready, bus.v3, bus.v2, bus.v1, bus.v0, bus.y3, bus.y2, bus.y1, bus.y0};
   endfunction

   // Expected outputs: the buffer holds at most the oldest unaccepted-for-delivery word
   function automatic logic [VW-1:0] exp_vec();
      logic [3:0]   rv;
      logic [3:0]   vv;
      logic [W-1:0] yv [4];
      logic         rdy;
      rv  = {bus.r3, bus.r2, bus.r1, bus.r0};
      vv  = 4'b0;
      for (int k = 0; k < 4; k++) yv[k] = '0;
      rdy = 1'b1;
      if (q.size() != 0) begin
         vv[q[0].s] = 1'b1;
         yv[q[0].s] = q[0].d;
         rdy        = rv[q[0].s];
      end
      return {rdy, vv, yv[3], yv[2], yv[1], yv[0]};
   endfunction

   function automatic logic [31:0] exp_cnt();
      return {8'(cnt_m[3]), 8'(cnt_m[2]), 8'(cnt_m[1]), 8'(cnt_m[0])};
   endfunction

   task automatic drive(input logic valid, input logic [1:0] s, input logic [W-1:0] d,
                        input logic [3:0] r);
      bus.in_valid = valid;
      bus.s        = s;
      bus.d        = d;
      {bus.r3, bus.r2, bus.r1, bus.r0} = r;
   endtask

   // Advance one clock and update the model from the inputs seen at the edge
   task automatic cyc();
      logic [3:0] rv;
      logic       drn, acc;
      item_t      it;
      rv  = {bus.r3, bus.r2, bus.r1, bus.r0};
      drn = (q.size() != 0) && rv[q[0].s];
      acc = bus.in_valid && ((q.size() == 0) || drn);
      it  = '{s: bus.s, d: bus.d};
      @(posedge clk);
      if (drn) begin
         cnt_m[q[0].s] = (cnt_m[q[0].s] + 1) % 256;
         void'(q.pop_front());
      end
      if (acc) q.push_back(it);
      #1;
   endtask

   task automatic model_clear();
      q.delete();
      for (int k = 0; k < 4; k++) cnt_m[k] = 0;
   endtask

   task automatic test_reset();
      drive(1'b0, 2'd0, '0, 4'h0);
      rst = 1'b1;
      model_clear();
      @(posedge clk); #1;
      checks++;
      if (obs_vec() !== {1'b1, 36'b0}) begin
         errors++;
         $display("FAIL reset_state obs=%h exp=%h", obs_vec(), {1'b1, 36'b0});
      end
`ifdef WB_DEMUX_CNT_EN
      checks++;
      if (cnt !== 32'h0) begin
         errors++;
         $display("FAIL reset_cnt obs=%h exp=0", cnt);
      end
`endif
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 2'd2, 8'h3C, 4'h0);
      cyc();
      drive(1'b0, 2'd0, 8'h00, 4'h0);
      #1;
      checks++;
      if (bus.v2 !== 1'b1 || bus.y2 !== 8'h3C || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_full v2=%b y2=%h rdy=%b exp v2=1 y2=3c rdy=0",
                  bus.v2, bus.y2, bus.in_ready);
      end
      #2;
      rst = 1'b1;
      model_clear();
      #1;
      checks++;
      if (obs_vec() !== {1'b1, 36'b0}) begin
         errors++;
         $display("FAIL rstmid_async obs=%h exp=%h", obs_vec(), {1'b1, 36'b0});
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic test_single();
      drive(1'b1, 2'd1, 8'hA5, 4'b0010);
      cyc();
      drive(1'b0, 2'd0, 8'h00, 4'b0010);
      #1;
      checks++;
      if (obs_vec() !== {1'b1, 4'b0010, 8'h00, 8'h00, 8'hA5, 8'h00}) begin
         errors++;
         $display("FAIL single_deliver obs=%h exp=%h", obs_vec(),
                  {1'b1, 4'b0010, 8'h00, 8'h00, 8'hA5, 8'h00});
      end
      cyc();
      checks++;
      if (obs_vec() !== {1'b1, 36'b0}) begin
         errors++;
         $display("FAIL single_drained obs=%h exp=%h", obs_vec(), {1'b1, 36'b0});
      end
   endtask

   task automatic test_backpressure();
      drive(1'b1, 2'd3, 8'h77, 4'h0);
      cyc();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 2'($urandom_range(0, 3)), W'($urandom), 4'b0111);
         #1;
         checks++;
         if (bus.in_ready !== 1'b0 || bus.v3 !== 1'b1 || bus.y3 !== 8'h77) begin
            errors++;
            $display("FAIL bp_hold cyc=%0d rdy=%b v3=%b y3=%h exp rdy=0 v3=1 y3=77",
                     i, bus.in_ready, bus.v3, bus.y3);
         end
         cyc();
      end
      drive(1'b1, 2'd0, 8'h42, 4'b1000);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release_ready obs=%b exp=1", bus.in_ready);
      end
      cyc();
      drive(1'b0, 2'd0, 8'h00, 4'b0000);
      #1;
      checks++;
      if (obs_vec() !== {1'b0, 4'b0001, 8'h00, 8'h00, 8'h00, 8'h42}) begin
         errors++;
         $display("FAIL bp_swap obs=%h exp=%h", obs_vec(),
                  {1'b0, 4'b0001, 8'h00, 8'h00, 8'h00, 8'h42});
      end
   endtask

   task automatic test_wrong_ready();
      // ch0 still holds 8'h42 from the previous scenario
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 2'd1, 8'h99, 4'b1110);
         #1;
         checks++;
         if (bus.in_ready !== 1'b0 || bus.v0 !== 1'b1 || bus.y0 !== 8'h42) begin
            errors++;
            $display("FAIL other_ready cyc=%0d rdy=%b v0=%b y0=%h exp rdy=0 v0=1 y0=42",
                     i, bus.in_ready, bus.v0, bus.y0);
         end
         cyc();
      end
      drive(1'b0, 2'd0, 8'h00, 4'b0001);
      cyc();
   endtask

   task automatic test_stream();
      logic [3:0]   vv;
      logic [W-1:0] yy;
      for (int i = 0; i < 9; i++) begin
         if (i < 8) drive(1'b1, 2'(i % 4), W'(i + 1), 4'hF);
         else       drive(1'b0, 2'd0, 8'h00, 4'hF);
         #1;
         if (i > 0) begin
            vv = 4'b0001 << ((i - 1) % 4);
            yy = W'(i);
            checks++;
            if ({bus.v3, bus.v2, bus.v1, bus.v0} !== vv || obs_vec() !== exp_vec() ||
                bus.in_ready !== 1'b1) begin
               errors++;
               $display("FAIL stream word=%0d v=%b rdy=%b obs=%h exp v=%b y=%h rdy=1",
                        i, {bus.v3, bus.v2, bus.v1, bus.v0}, bus.in_ready, obs_vec(), vv, yy);
            end
            checks++;
            if ((vv[0] && bus.y0 !== yy) || (vv[1] && bus.y1 !== yy) ||
                (vv[2] && bus.y2 !== yy) || (vv[3] && bus.y3 !== yy)) begin
               errors++;
               $display("FAIL stream_data word=%0d y=%h/%h/%h/%h exp=%h",
                        i, bus.y3, bus.y2, bus.y1, bus.y0, yy);
            end
         end
         cyc();
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 99) < 70, 2'($urandom_range(0, 3)), W'($urandom),
               4'($urandom) | (($urandom_range(0, 1) != 0) ? 4'hF : 4'h0));
         #1;
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL random cyc=%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
         end
`ifdef WB_DEMUX_CNT_EN
         checks++;
         if (cnt !== exp_cnt()) begin
            errors++;
            $display("FAIL random_cnt cyc=%0d obs=%h exp=%h", i, cnt, exp_cnt());
         end
`endif
         cyc();
      end
      drive(1'b0, 2'd0, 8'h00, 4'hF);
      cyc();
   endtask

`ifdef WB_DEMUX_CNT_EN
   task automatic test_cnt();
      test_reset();
      for (int i = 0; i < 258; i++) begin
         drive(i < 257, 2'd2, W'($urandom), 4'b0100);
         cyc();
      end
      drive(1'b0, 2'd0, 8'h00, 4'h0);
      #1;
      checks++;
      if (cnt !== 32'h0001_0000 || cnt !== exp_cnt()) begin
         errors++;
         $display("FAIL cnt_wrap obs=%h exp=%h", cnt, 32'h0001_0000);
      end
   endtask
`endif

   initial begin
      model_clear();
      drive(1'b0, 2'd0, '0, 4'h0);
      test_reset();
      test_reset_mid();
      test_single();
      test_backpressure();
      test_wrong_ready();
      test_stream();
      test_random();
`ifdef WB_DEMUX_CNT_EN
      test_cnt();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
